// File: rtl/model_xform_if.sv
// ============================================================================
// model_xform_if : pose configuration, vertex-in and vertex-out handshakes
// Revision: 1.0
// ============================================================================
`default_nettype none

interface model_xform_if #(
    parameter int VCOUNT_W = 16
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [31:0]         cfg_pos_x;
    logic [31:0]         cfg_pos_y;
    logic [31:0]         cfg_pos_z;
    logic [31:0]         cfg_q_w;
    logic [31:0]         cfg_q_x;
    logic [31:0]         cfg_q_y;
    logic [31:0]         cfg_q_z;
    logic [VCOUNT_W-1:0] cfg_vcount;

    logic                vin_valid;
    logic                vin_ready;
    logic [31:0]         vin_x;
    logic [31:0]         vin_y;
    logic [31:0]         vin_z;

    logic                vout_valid;
    logic                vout_ready;
    logic [31:0]         vout_x;
    logic [31:0]         vout_y;
    logic [31:0]         vout_z;
    logic                vout_last;

    logic                busy;

    modport master (
        output cfg_valid, cfg_pos_x, cfg_pos_y, cfg_pos_z,
               cfg_q_w, cfg_q_x, cfg_q_y, cfg_q_z, cfg_vcount,
               vin_valid, vin_x, vin_y, vin_z, vout_ready,
        input  cfg_ready, vin_ready, vout_valid, vout_x, vout_y, vout_z,
               vout_last, busy
    );

    modport slave (
        input  cfg_valid, cfg_pos_x, cfg_pos_y, cfg_pos_z,
               cfg_q_w, cfg_q_x, cfg_q_y, cfg_q_z, cfg_vcount,
               vin_valid, vin_x, vin_y, vin_z, vout_ready,
        output cfg_ready, vin_ready, vout_valid, vout_x, vout_y, vout_z,
               vout_last, busy
    );
endinterface

`default_nettype wire

// File: rtl/model_xform.sv
// ============================================================================
// model_xform : quaternion pose -> rotation matrix, then streams model-space
//               vertices to world space (Q16.16, one vertex per cycle)
// Revision: 1.0
// ============================================================================
`default_nettype none

module model_xform #(
    parameter int VCOUNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    model_xform_if.slave bus
);

    localparam logic [31:0] ONE = 32'h0001_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUILD0 = 2'd1,
        BUILD1 = 2'd2,
        STREAM = 2'd3
    } state_t;

    state_t              state;
    logic [VCOUNT_W-1:0] remaining;
    logic [31:0]         pos_x, pos_y, pos_z;
    logic [31:0]         q_w, q_x, q_y, q_z;
    logic [31:0]         xx, yy, zz, xy, xz, yz, wx, wy, wz;
    logic [31:0]         m00, m01, m02, m10, m11, m12, m20, m21, m22;
    logic [31:0]         out_x, out_y, out_z;
    logic                out_valid;
    logic                out_last;

    logic                vin_ready_w;
    logic                cfg_fire;
    logic                vin_fire;
    logic                vout_fire;
    logic [31:0]         nx, ny, nz;

    // Full 64-bit signed product, floor shift by 16, low 32 bits kept.
    function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return 32'(p >>> 16);
    endfunction

    assign vin_ready_w = (state == STREAM) && (remaining != '0) &&
                         (!out_valid || bus.vout_ready);
    assign cfg_fire    = bus.cfg_valid && (state == IDLE);
    assign vin_fire    = bus.vin_valid && vin_ready_w;
    assign vout_fire   = out_valid && bus.vout_ready;

    assign nx = qmul(m00, bus.vin_x) + qmul(m01, bus.vin_y) + qmul(m02, bus.vin_z) + pos_x;
    assign ny = qmul(m10, bus.vin_x) + qmul(m11, bus.vin_y) + qmul(m12, bus.vin_z) + pos_y;
    assign nz = qmul(m20, bus.vin_x) + qmul(m21, bus.vin_y) + qmul(m22, bus.vin_z) + pos_z;

    assign bus.cfg_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.vin_ready  = vin_ready_w;
    assign bus.vout_valid = out_valid;
    assign bus.vout_x     = out_x;
    assign bus.vout_y     = out_y;
    assign bus.vout_z     = out_z;
    assign bus.vout_last  = out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            pos_x <= '0; pos_y <= '0; pos_z <= '0;
            q_w   <= '0; q_x   <= '0; q_y   <= '0; q_z <= '0;
            xx <= '0; yy <= '0; zz <= '0; xy <= '0; xz <= '0;
            yz <= '0; wx <= '0; wy <= '0; wz <= '0;
            m00 <= '0; m01 <= '0; m02 <= '0;
            m10 <= '0; m11 <= '0; m12 <= '0;
            m20 <= '0; m21 <= '0; m22 <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        pos_x     <= bus.cfg_pos_x;
                        pos_y     <= bus.cfg_pos_y;
                        pos_z     <= bus.cfg_pos_z;
                        q_w       <= bus.cfg_q_w;
                        q_x       <= bus.cfg_q_x;
                        q_y       <= bus.cfg_q_y;
                        q_z       <= bus.cfg_q_z;
                        remaining <= bus.cfg_vcount;
                        state     <= BUILD0;
                    end
                end
                BUILD0: begin
                    xx <= qmul(q_x, q_x);
                    yy <= qmul(q_y, q_y);
                    zz <= qmul(q_z, q_z);
                    xy <= qmul(q_x, q_y);
                    xz <= qmul(q_x, q_z);
                    yz <= qmul(q_y, q_z);
                    wx <= qmul(q_w, q_x);
                    wy <= qmul(q_w, q_y);
                    wz <= qmul(q_w, q_z);
                    state <= BUILD1;
                end
                BUILD1: begin
                    m00 <= ONE - ((yy + zz) << 1);
                    m01 <= (xy - wz) << 1;
                    m02 <= (xz + wy) << 1;
                    m10 <= (xy + wz) << 1;
                    m11 <= ONE - ((xx + zz) << 1);
                    m12 <= (yz - wx) << 1;
                    m20 <= (xz - wy) << 1;
                    m21 <= (yz + wx) << 1;
                    m22 <= ONE - ((xx + yy) << 1);
                    state <= (remaining != '0) ? STREAM : IDLE;
                end
                STREAM: begin
                    // A new result may replace one being accepted in the same cycle.
                    if (vin_fire) begin
                        out_x     <= nx;
                        out_y     <= ny;
                        out_z     <= nz;
                        out_valid <= 1'b1;
                        out_last  <= (remaining == VCOUNT_W'(1));
                        remaining <= remaining - VCOUNT_W'(1);
                    end else if (vout_fire) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    if (vout_fire && out_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_model_xform.sv
// ============================================================================
// tb_model_xform : directed and randomized checks of model_xform against a
//                  fixed-point reference model with an expected-output queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_model_xform;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] vtx_x [16];
    logic [31:0] vtx_y [16];
    logic [31:0] vtx_z [16];
    logic [31:0] mtx   [9];
    logic [31:0] obs_x, obs_y, obs_z;
    logic        obs_last;
    int          g_first, g_last, g_got;

    always #5 clk = ~clk;

    model_xform_if #(.VCOUNT_W(16)) bus ();

    model_xform #(.VCOUNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        longint pa, pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 32'((pa * pb) >>> 16);
    endfunction

    // Rotation matrix of quaternion (w,x,y,z), row-major.
    task automatic build_matrix(input logic [31:0] w, x, y, z);
        logic [31:0] one;
        one = 32'h0001_0000;
        mtx[0] = one - 2 * (fmul(y, y) + fmul(z, z));
        mtx[1] = 2 * (fmul(x, y) - fmul(w, z));
        mtx[2] = 2 * (fmul(x, z) + fmul(w, y));
        mtx[3] = 2 * (fmul(x, y) + fmul(w, z));
        mtx[4] = one - 2 * (fmul(x, x) + fmul(z, z));
        mtx[5] = 2 * (fmul(y, z) - fmul(w, x));
        mtx[6] = 2 * (fmul(x, z) - fmul(w, y));
        mtx[7] = 2 * (fmul(y, z) + fmul(w, x));
        mtx[8] = one - 2 * (fmul(x, x) + fmul(y, y));
    endtask

    function automatic exp_t xform(input int i, input logic [31:0] px, py, pz, input bit last);
        logic [31:0] v [3];
        logic [31:0] acc [3];
        exp_t e;
        v[0] = vtx_x[i]; v[1] = vtx_y[i]; v[2] = vtx_z[i];
        acc[0] = px; acc[1] = py; acc[2] = pz;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                acc[r] = acc[r] + fmul(mtx[r*3+c], v[c]);
        e.x = acc[0]; e.y = acc[1]; e.z = acc[2]; e.last = last;
        return e;
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            vtx_x[i] = $urandom;
            vtx_y[i] = $urandom;
            vtx_z[i] = $urandom;
        end
    endtask

    // One model: cfg handshake, then per-cycle drive/check until the last output
    // is accepted. stall_at/stall_len hold vout_ready low; abort_after >= 0 pulses
    // reset once that many vertices have been accepted.
    task automatic run_model(input logic [31:0] qw, qx, qy, qz, px, py, pz,
                             input int cnt, input int stall_at, input int stall_len,
                             input bit rnd, input int abort_after);
        exp_t q[$];
        exp_t e;
        int   sent, k;
        bit   done, exp_vin_rdy, vin_f, vout_f;
        sent = 0; done = 1'b0; g_got = 0; g_first = -1; g_last = -1;
        build_matrix(qw, qx, qy, qz);

        @(posedge clk); #1;
        bus.cfg_valid = 1'b1;
        bus.cfg_q_w = qw; bus.cfg_q_x = qx; bus.cfg_q_y = qy; bus.cfg_q_z = qz;
        bus.cfg_pos_x = px; bus.cfg_pos_y = py; bus.cfg_pos_z = pz;
        bus.cfg_vcount = 16'(cnt);
        @(negedge clk);
        chk("cfg_ready_idle", {31'd0, bus.cfg_ready}, 32'd1);
        @(posedge clk); #1;

        for (k = 1; k <= 400 && !done; k++) begin
            bus.cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.cfg_q_w = $urandom; bus.cfg_pos_x = $urandom; bus.cfg_vcount = 16'($urandom);
            bus.vin_valid = rnd ? ($urandom_range(0, 3) != 0) : (sent < cnt);
            bus.vin_x = (sent < cnt) ? vtx_x[sent] : $urandom;
            bus.vin_y = (sent < cnt) ? vtx_y[sent] : $urandom;
            bus.vin_z = (sent < cnt) ? vtx_z[sent] : $urandom;
            bus.vout_ready = (k >= stall_at && k < stall_at + stall_len) ? 1'b0 :
                             (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            @(negedge clk);
            exp_vin_rdy = (k >= 3) && (cnt > 0) && (sent < cnt) &&
                          (q.size() == 0 || bus.vout_ready);
            chk("busy", {31'd0, bus.busy}, 32'd1);
            chk("cfg_ready_busy", {31'd0, bus.cfg_ready}, 32'd0);
            chk("vin_ready", {31'd0, bus.vin_ready}, {31'd0, exp_vin_rdy});
            chk("vout_valid", {31'd0, bus.vout_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0 && bus.vout_valid) begin
                chk("vout_x", bus.vout_x, q[0].x);
                chk("vout_y", bus.vout_y, q[0].y);
                chk("vout_z", bus.vout_z, q[0].z);
                chk("vout_last", {31'd0, bus.vout_last}, {31'd0, q[0].last});
                obs_x = bus.vout_x; obs_y = bus.vout_y; obs_z = bus.vout_z;
                obs_last = bus.vout_last;
            end
            if (abort_after >= 0 && sent == abort_after && q.size() != 0) begin
                rst_n = 1'b0;
                #1;
                chk("abort_vout_valid", {31'd0, bus.vout_valid}, 32'd0);
                chk("abort_vout_last", {31'd0, bus.vout_last}, 32'd0);
                chk("abort_busy", {31'd0, bus.busy}, 32'd0);
                chk("abort_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
                chk("abort_vin_ready", {31'd0, bus.vin_ready}, 32'd0);
                bus.vin_valid = 1'b0;
                bus.cfg_valid = 1'b0;
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            vin_f  = bus.vin_valid && exp_vin_rdy;
            vout_f = (q.size() != 0) && bus.vout_ready;
            if (vout_f) begin
                e = q.pop_front();
                g_got++;
                if (g_first < 0) g_first = k;
                g_last = k;
                if (e.last) done = 1'b1;
            end
            if (vin_f) begin
                q.push_back(xform(sent, px, py, pz, sent == cnt - 1));
                sent++;
            end
            if (cnt == 0 && k == 2) done = 1'b1;
            @(posedge clk); #1;
        end

        if (!done) begin
            errors++;
            $error("FAIL timeout: model with count %0d never completed", cnt);
        end
        bus.cfg_valid = 1'b0;
        bus.vin_valid = 1'b0;
        @(negedge clk);
        chk("end_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
        chk("end_busy", {31'd0, bus.busy}, 32'd0);
        chk("end_vout_valid", {31'd0, bus.vout_valid}, 32'd0);
        chk("out_count", 32'(g_got), 32'(cnt));
    endtask

    initial begin
        bus.cfg_valid = 1'b0; bus.vin_valid = 1'b0; bus.vout_ready = 1'b0;
        bus.cfg_pos_x = '0; bus.cfg_pos_y = '0; bus.cfg_pos_z = '0;
        bus.cfg_q_w = '0; bus.cfg_q_x = '0; bus.cfg_q_y = '0; bus.cfg_q_z = '0;
        bus.cfg_vcount = '0;
        bus.vin_x = '0; bus.vin_y = '0; bus.vin_z = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_vout_valid", {31'd0, bus.vout_valid}, 32'd0);
        chk("rst_vin_ready", {31'd0, bus.vin_ready}, 32'd0);
        chk("rst_vout_last", {31'd0, bus.vout_last}, 32'd0);
        chk("rst_vout_x", bus.vout_x, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Identity rotation with translation
        vtx_x[0] = 32'h10000; vtx_y[0] = 32'h0; vtx_z[0] = 32'h0;
        run_model(32'h10000, 0, 0, 0, 32'h10000, 32'h20000, 32'h30000, 1, 0, 0, 1'b0, -1);
        chk("ident_x", obs_x, 32'h20000);
        chk("ident_y", obs_y, 32'h20000);
        chk("ident_z", obs_z, 32'h30000);
        chk("ident_last", {31'd0, obs_last}, 32'd1);

        // 90 degrees about z
        run_model(32'hB505, 0, 0, 32'hB505, 0, 0, 0, 1, 0, 0, 1'b0, -1);
        chk("rotz_x", obs_x, 32'h0);
        chk("rotz_y", obs_y, 32'h10000);
        chk("rotz_z", obs_z, 32'h0);

        // Back-pressure mid-stream
        fill_random(4);
        run_model(32'hB505, 32'hB505, 0, 0, 32'h12345, 32'hFFFF0000, 32'h7, 4, 5, 5, 1'b0, -1);

        // Empty model
        run_model($urandom, $urandom, $urandom, $urandom, 1, 2, 3, 0, 0, 0, 1'b0, -1);

        // Reset mid-stream, then a fresh single-vertex model
        fill_random(5);
        run_model(32'h10000, 0, 0, 0, 32'h5, 32'h6, 32'h7, 5, 0, 0, 1'b0, 2);
        fill_random(1);
        run_model(32'hDDB4, 32'h4000, 32'h4000, 32'h4000, $urandom, $urandom, $urandom,
                  1, 0, 0, 1'b0, -1);

        // Full throughput
        fill_random(8);
        run_model(32'h8000, 32'h8000, 32'h8000, 32'h8000, $urandom, $urandom, $urandom,
                  8, 0, 0, 1'b0, -1);
        chk("burst_span", 32'(g_last - g_first), 32'd7);

        // Randomized models with random handshakes
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 12);
            fill_random(n);
            run_model($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      n, 0, 0, 1'b1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
